// File: rtl/sram_like_to_axi.sv
// Merges the instruction and data sram-like request streams onto one AXI3 master.
// One transaction in flight at a time; the data port wins arbitration in IDLE.
module sram_like_to_axi #(
    parameter int ID_W    = 4,
    parameter int INST_ID = 0,
    parameter int DATA_ID = 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            inst_req,
    input  logic            inst_wr,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    input  logic [31:0]     inst_wdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,
    output logic [31:0]     inst_rdata,

    input  logic            data_req,
    input  logic            data_wr,
    input  logic [1:0]      data_size,
    input  logic [31:0]     data_addr,
    input  logic [31:0]     data_wdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    output logic [31:0]     data_rdata,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        src_q, src_d;          // 1 = data port owns the transaction
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic        idle;
    logic        txn_done;
    logic [ID_W-1:0] txn_id;
    logic        unused_rid;

    assign unused_rid = ^rid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            src_q     <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (data_req) begin
                    src_d   = 1'b1;
                    size_d  = data_size;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    state_d = data_wr ? WR_REQ : RD_ADDR;
                end else if (inst_req) begin
                    src_d   = 1'b0;
                    size_d  = inst_size;
                    addr_d  = inst_addr;
                    wdata_d = inst_wdata;
                    state_d = inst_wr ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: if (arready) state_d = RD_DATA;
            RD_DATA: if (rvalid && rlast) state_d = IDLE;
            WR_REQ: begin
                // Sticky flags let AW and W complete in either order or together.
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: if (bvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign idle         = (state_q == IDLE);
    assign data_addr_ok = rst & idle & data_req;
    assign inst_addr_ok = rst & idle & inst_req & ~data_req;

    assign txn_done     = ((state_q == RD_DATA) & rvalid & rlast) |
                          ((state_q == WR_RESP) & bvalid);
    assign inst_data_ok = txn_done & ~src_q;
    assign data_data_ok = txn_done & src_q;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign txn_id  = src_q ? ID_W'(DATA_ID) : ID_W'(INST_ID);

    assign arid    = txn_id;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arvalid = (state_q == RD_ADDR);
    assign rready  = (state_q == RD_DATA);

    assign awid    = txn_id;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awvalid = (state_q == WR_REQ) & ~aw_done_q;
    assign wdata   = wdata_q;
    assign wlast   = 1'b1;
    assign wvalid  = (state_q == WR_REQ) & ~w_done_q;
    assign bready  = (state_q == WR_RESP);

    always_comb begin
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

endmodule

// File: tb/tb_sram_like_to_axi.sv
// Directed bench for sram_like_to_axi: a vector table of single transactions
// plus hand-written sequences for arbitration, stalls, split write handshakes and reset.
module tb_sram_like_to_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic [3:0]  arid, rid, awid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_to_axi dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        if (v.is_data) begin
            data_req = 1'b1; data_wr = v.wr; data_size = v.size;
            data_addr = v.addr; data_wdata = v.wdat;
        end else begin
            inst_req = 1'b1; inst_wr = v.wr; inst_size = v.size;
            inst_addr = v.addr; inst_wdata = v.wdat;
        end
        #1;
        chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, ~v.is_data});
        chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, v.is_data});
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0;
        #1;
        if (!v.wr) begin
            chk("arvalid", {31'd0, arvalid}, 32'd1);
            chk("araddr", araddr, v.addr);
            chk("arid", {28'd0, arid}, {31'd0, v.is_data});
            chk("arsize", {29'd0, arsize}, {30'd0, v.size});
            chk("arlen", {24'd0, arlen}, 32'd0);
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = v.rdat;
            #1;
            chk("rready", {31'd0, rready}, 32'd1);
            chk("rd_data_ok", {30'd0, inst_data_ok, data_data_ok}, v.is_data ? 32'd1 : 32'd2);
            chk("rd_rdata", v.is_data ? data_rdata : inst_rdata, v.rdat);
            @(negedge clk);
            rvalid = 1'b0; rlast = 1'b0;
            #1;
            chk("rd_idle_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            chk("rd_idle_rready", {31'd0, rready}, 32'd0);
        end else begin
            chk("aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
            chk("awaddr", awaddr, v.addr);
            chk("awid", {28'd0, awid}, {31'd0, v.is_data});
            chk("awsize", {29'd0, awsize}, {30'd0, v.size});
            chk("wstrb", {28'd0, wstrb}, {28'd0, v.exp_wstrb});
            chk("wdata", wdata, v.wdat);
            chk("wlast_awlen", {23'd0, wlast, awlen}, 32'h100);
            awready = 1'b1; wready = 1'b1;
            @(negedge clk);
            awready = 1'b0; wready = 1'b0;
            #1;
            chk("wr_resp_state", {29'd0, awvalid, wvalid, bready}, 32'd1);
            chk("wr_no_early_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            bvalid = 1'b1;
            #1;
            chk("wr_data_ok", {30'd0, inst_data_ok, data_data_ok}, v.is_data ? 32'd1 : 32'd2);
            @(negedge clk);
            bvalid = 1'b0;
            #1;
            chk("wr_idle_bready", {31'd0, bready}, 32'd0);
        end
        $display("txn %0d: %s %s addr=0x%08h size=%0d done (errors so far %0d)",
                 idx, v.is_data ? "data" : "inst", v.wr ? "write" : "read", v.addr, v.size, errors);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0,        32'h3C1DBFC0, 4'b0000};
        vecs[1] = '{1'b1, 1'b0, 2'd2, 32'h80000010, 32'h0,        32'h12345678, 4'b0000};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 32'h80000003, 32'hAB000000, 32'h0,        4'b1000};
        vecs[3] = '{1'b1, 1'b1, 2'd1, 32'h80000002, 32'hBEEF0000, 32'h0,        4'b1100};
        vecs[4] = '{1'b1, 1'b1, 2'd0, 32'h80000001, 32'h00005A00, 32'h0,        4'b0010};
        vecs[5] = '{1'b0, 1'b1, 2'd2, 32'h00000004, 32'hDEADBEEF, 32'h0,        4'b1111};
        vecs[6] = '{1'b1, 1'b0, 2'd1, 32'h80000006, 32'h0,        32'hA5A55A5A, 4'b0000};
        vecs[7] = '{1'b1, 1'b1, 2'd1, 32'h80000000, 32'h00001234, 32'h0,        4'b0011};
        vecs[8] = '{1'b1, 1'b1, 2'd3, 32'h80000008, 32'h01020304, 32'h0,        4'b1111};

        rst = 1'b0;
        inst_req = 1'b1; data_req = 1'b1; inst_wr = 1'b0; data_wr = 1'b0;
        inst_size = 2'd0; data_size = 2'd0;
        inst_addr = 32'd0; data_addr = 32'd0; inst_wdata = 32'd0; data_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
        chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        @(negedge clk);
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Simultaneous requests: data wins, inst waits for the next IDLE
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000010;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC00004;
        #1;
        chk("arb_data_ok", {31'd0, data_addr_ok}, 32'd1);
        chk("arb_inst_blocked", {31'd0, inst_addr_ok}, 32'd0);
        @(negedge clk);
        data_req = 1'b0;
        #1;
        chk("arb_arid", {28'd0, arid}, 32'd1);
        chk("arb_araddr", araddr, 32'h80000010);
        chk("arb_inst_busy", {31'd0, inst_addr_ok}, 32'd0);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hCAFEF00D;
        #1;
        chk("arb_data_ok_route", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        chk("arb_data_rdata", data_rdata, 32'hCAFEF00D);
        chk("arb_inst_busy2", {31'd0, inst_addr_ok}, 32'd0);
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("arb_inst_accept", {31'd0, inst_addr_ok}, 32'd1);
        @(negedge clk);
        inst_req = 1'b0;
        #1;
        chk("arb_inst_arid", {28'd0, arid}, 32'd0);
        chk("arb_inst_araddr", araddr, 32'hBFC00004);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h11223344;
        #1;
        chk("arb_inst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        chk("arb_inst_rdata", inst_rdata, 32'h11223344);
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        $display("txn arb: data read then queued inst read done (errors so far %0d)", errors);

        // Byte write with AW accepted two cycles before W
        begin
            int ok_cnt;
            ok_cnt = 0;
            @(negedge clk);
            data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
            data_addr = 32'h80000003; data_wdata = 32'hAB000000;
            @(negedge clk);
            data_req = 1'b0;
            #1;
            chk("split_both_valid", {30'd0, awvalid, wvalid}, 32'd3);
            chk("split_wstrb", {28'd0, wstrb}, 32'h8);
            awready = 1'b1;
            @(negedge clk);
            awready = 1'b0;
            #1;
            chk("split_aw_dropped", {30'd0, awvalid, wvalid}, 32'd1);
            @(negedge clk);
            #1;
            chk("split_w_held", {29'd0, awvalid, wvalid, bready}, 32'd2);
            wready = 1'b1;
            @(negedge clk);
            wready = 1'b0;
            #1;
            chk("split_resp", {29'd0, awvalid, wvalid, bready}, 32'd1);
            bvalid = 1'b1;
            #1;
            ok_cnt += int'(data_data_ok);
            chk("split_inst_quiet", {31'd0, inst_data_ok}, 32'd0);
            @(negedge clk);
            bvalid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                #1;
                ok_cnt += int'(data_data_ok);
                @(negedge clk);
            end
            chk("split_one_data_ok", ok_cnt, 32'd1);
            $display("txn split: byte write AW-before-W done (errors so far %0d)", errors);
        end

        // arready stall: address held stable, no new accept
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000030;
        @(negedge clk);
        data_req = 1'b0; inst_req = 1'b1; inst_wr = 1'b0; inst_addr = 32'h00001234;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
            chk("stall_araddr", araddr, 32'h80000030);
            chk("stall_no_accept", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
            @(negedge clk);
        end
        arready = 1'b1;
        #1;
        chk("stall_release_arvalid", {31'd0, arvalid}, 32'd1);
        @(negedge clk);
        arready = 1'b0; inst_req = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0BADF00D;
        #1;
        chk("stall_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        $display("txn stall: 5-cycle arready stall done (errors so far %0d)", errors);

        // Reset asserted during RD_DATA abandons the read
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000040;
        @(negedge clk);
        data_req = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #1;
        chk("rstmid_rready", {31'd0, rready}, 32'd1);
        rst = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hFFFFFFFF;
        #1;
        chk("rstmid_valids", {29'd0, arvalid, rready, bready}, 32'd0);
        chk("rstmid_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        @(negedge clk);
        rst = 1'b1; rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("rstmid_post_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        $display("txn rstmid: read abandoned by reset (errors so far %0d)", errors);
        run_vec(vecs[1], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
